// File: rtl/perceptron_mac_sequencer.sv
// perceptron_mac_sequencer: drives one registered multiplier through an N-input dot product,
// accumulates in two's complement, adds bias and returns a saturated sign-magnitude result.
module perceptron_mac_sequencer #(
    parameter int SIGN     = 1,
    parameter int Q_M      = 16,
    parameter int Q_N      = 16,
    parameter int N_INPUTS = 4,
    localparam int W     = SIGN + Q_M + Q_N,
    localparam int AW    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    localparam int ACC_W = Q_M + Q_N + 2 + $clog2(N_INPUTS + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    output logic [AW-1:0] idx_o,
    input  logic [W-1:0]  x_i,
    input  logic [W-1:0]  w_i,
    input  logic [W-1:0]  bias_i,
    output logic [W-1:0]  mul_a_o,
    output logic [W-1:0]  mul_b_o,
    input  logic [W-1:0]  mul_y_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [W-1:0]  y_o,
    output logic          sat_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    state_t                   state_q;
    logic [AW-1:0]            idx_q;
    logic                     pv_q, done_q, sat_q;
    logic [W-1:0]             y_q;
    logic signed [ACC_W-1:0]  acc_q, acc_d, sum_d;
    logic [ACC_W-1:0]         mag_d;
    logic                     sat_d;
    logic [W-1:0]             y_d;

    function automatic logic signed [ACC_W-1:0] to_tc(input logic [W-1:0] v);
        logic signed [ACC_W-1:0] m;
        m = {{(ACC_W-W+1){1'b0}}, v[W-2:0]};
        return v[W-1] ? -m : m;
    endfunction

    // Accumulator is wide enough for N full-scale products plus bias, so it never wraps.
    always_comb begin
        acc_d = acc_q + to_tc(mul_y_i);
        sum_d = acc_q + to_tc(bias_i);
        mag_d = sum_d[ACC_W-1] ? -sum_d : sum_d;
        sat_d = |mag_d[ACC_W-1:W-1];
        y_d   = {sum_d[ACC_W-1], sat_d ? {(W-1){1'b1}} : mag_d[W-2:0]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pv_q    <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            y_q     <= '0;
            acc_q   <= '0;
        end else begin
            pv_q   <= (state_q == RUN);
            done_q <= (state_q == FINISH);
            if (pv_q) acc_q <= acc_d;
            case (state_q)
                IDLE: if (start_i) begin
                    acc_q   <= '0;
                    idx_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    idx_q   <= (idx_q == AW'(N_INPUTS-1)) ? '0 : idx_q + 1'b1;
                    state_q <= (idx_q == AW'(N_INPUTS-1)) ? DRAIN : RUN;
                end
                DRAIN: state_q <= FINISH;
                FINISH: begin
                    y_q     <= y_d;
                    sat_q   <= sat_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign idx_o   = idx_q;
    assign mul_a_o = (state_q == RUN) ? x_i : '0;
    assign mul_b_o = (state_q == RUN) ? w_i : '0;
    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign y_o     = y_q;
    assign sat_o   = sat_q;
endmodule
